// File: rtl/spi_master_multi.sv
// SPI master with runtime-selectable mode (CPOL/CPHA), bit order and
// transfer length, plus NCS chip selects with a minimum deselect gap.
// Every SPI-facing output is registered so SCK/MOSI/CSN are glitch-free.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a request; SCK parked at last cpol, CSN all high
// ST_SETUP | CS asserted, SCK at cpol, first bit on MOSI when cpha=0
// ST_SHIFT | 2n half-periods, SCK toggles at the end of each one
// ST_HOLD  | CS still asserted after the last SCK edge
// ST_GAP   | all CS released; minimum deselect time before next transfer
module spi_master_multi #(
   parameter  int DATA_W = 32,
   parameter  int NCS    = 2,
   parameter  int DIV    = 200,
   localparam int NB_W   = $clog2(DATA_W) + 1,
   localparam int CS_W   = (NCS > 1) ? $clog2(NCS) : 1
) (
   input  logic              clk_in,
   input  logic              nrst,
   input  logic              request,
   output logic              ready,
   output logic              done,
   input  logic [DATA_W-1:0] mosi_data,
   output logic [DATA_W-1:0] miso_data,
   input  logic [NB_W-1:0]   nbits,
   input  logic [CS_W-1:0]   cs_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic              lsb_first,
   output logic              spi_sck,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic [NCS-1:0]    spi_csn
);

   localparam int                DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int                HP_W   = NB_W + 1;
   localparam logic [DIV_W-1:0]  DIV_LD = DIV_W'(DIV - 1);
   localparam logic [NB_W-1:0]   NB_MAX = NB_W'(DATA_W);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_t;

   state_t            state_q,   state_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [HP_W-1:0]   hp_cnt_q,  hp_cnt_d;
   logic [NB_W-1:0]   n_q,       n_d;
   logic              cpha_q,    cpha_d;
   logic              lsb_q,     lsb_d;
   logic [DATA_W-1:0] tx_q,      tx_d;
   logic [DATA_W-1:0] rx_q,      rx_d;
   logic [DATA_W-1:0] miso_q,    miso_d;
   logic              done_q,    done_d;
   logic              sck_q,     sck_d;
   logic              mosi_q,    mosi_d;
   logic [NCS-1:0]    csn_q,     csn_d;

   logic [NB_W-1:0]   n_clamp;
   logic [DATA_W-1:0] tx_align;
   logic              first_bit;
   logic [DATA_W-1:0] tx_align_sh;
   logic              cur_bit;
   logic [DATA_W-1:0] tx_shift;
   logic [DATA_W-1:0] rx_in;
   logic [DATA_W-1:0] rx_final;
   logic [NCS-1:0]    csn_sel;
   logic              div_tc;
   logic              leading;
   logic              last_hp;

   // Request-side helpers: clamp length and pre-align the word so the
   // first bit to send always sits at bit 0 (LSB-first) or the MSB.
   always_comb begin
      n_clamp     = (nbits == '0 || nbits > NB_MAX) ? NB_MAX : nbits;
      tx_align    = lsb_first ? mosi_data : (mosi_data << (NB_MAX - n_clamp));
      first_bit   = lsb_first ? tx_align[0] : tx_align[DATA_W-1];
      tx_align_sh = lsb_first ? (tx_align >> 1) : (tx_align << 1);
   end

   // Shift-path helpers for the transfer in flight.
   always_comb begin
      cur_bit  = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
      tx_shift = lsb_q ? (tx_q >> 1) : (tx_q << 1);
      // LSB-first fills from the top and is right-aligned at completion;
      // MSB-first fills from bit 0 so the first bit lands at n-1.
      rx_in    = lsb_q ? {spi_miso, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], spi_miso};
      rx_final = lsb_q ? (rx_q >> (NB_MAX - n_q)) : rx_q;
      div_tc   = (div_cnt_q == '0);
      // hp_cnt starts at 2n-1 (odd), so odd values end a leading half.
      leading  = hp_cnt_q[0];
      last_hp  = (hp_cnt_q == '0);
   end

   // Chip-select decode; an out-of-range select asserts nothing.
   always_comb begin
      csn_sel = '1;
      for (int i = 0; i < NCS; i++) begin
         if (cs_sel == CS_W'(i)) begin
            csn_sel[i] = 1'b0;
         end
      end
   end

   // Next-state and datapath updates for the transfer sequencer.
   always_comb begin
      state_d   = state_q;
      div_cnt_d = div_cnt_q;
      hp_cnt_d  = hp_cnt_q;
      n_d       = n_q;
      cpha_d    = cpha_q;
      lsb_d     = lsb_q;
      tx_d      = tx_q;
      rx_d      = rx_q;
      miso_d    = miso_q;
      done_d    = 1'b0;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      csn_d     = csn_q;

      if (state_q != ST_IDLE) begin
         div_cnt_d = div_tc ? DIV_LD : (div_cnt_q - DIV_W'(1));
      end

      case (state_q)
         ST_IDLE: begin
            if (request) begin
               state_d   = ST_SETUP;
               div_cnt_d = DIV_LD;
               n_d       = n_clamp;
               cpha_d    = cpha;
               lsb_d     = lsb_first;
               sck_d     = cpol;
               csn_d     = csn_sel;
               rx_d      = '0;
               tx_d      = tx_align;
               if (!cpha) begin
                  mosi_d = first_bit;
                  tx_d   = tx_align_sh;
               end
            end
         end

         ST_SETUP: begin
            if (div_tc) begin
               state_d  = ST_SHIFT;
               hp_cnt_d = {n_q, 1'b0} - HP_W'(1);
            end
         end

         ST_SHIFT: begin
            if (div_tc) begin
               sck_d = ~sck_q;
               if (leading) begin
                  if (cpha_q) begin
                     mosi_d = cur_bit;
                     tx_d   = tx_shift;
                  end else begin
                     rx_d = rx_in;
                  end
               end else begin
                  if (cpha_q) begin
                     rx_d = rx_in;
                  end else if (!last_hp) begin
                     mosi_d = cur_bit;
                     tx_d   = tx_shift;
                  end
               end
               if (last_hp) begin
                  state_d = ST_HOLD;
               end else begin
                  hp_cnt_d = hp_cnt_q - HP_W'(1);
               end
            end
         end

         ST_HOLD: begin
            if (div_tc) begin
               state_d = ST_GAP;
               csn_d   = '1;
            end
         end

         ST_GAP: begin
            if (div_tc) begin
               state_d   = ST_IDLE;
               div_cnt_d = '0;
               miso_d    = rx_final;
               done_d    = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            csn_d   = '1;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transfer at once.
   always_ff @(posedge clk_in or negedge nrst) begin
      if (!nrst) begin
         state_q   <= ST_IDLE;
         div_cnt_q <= '0;
         hp_cnt_q  <= '0;
         n_q       <= '0;
         cpha_q    <= 1'b0;
         lsb_q     <= 1'b0;
         tx_q      <= '0;
         rx_q      <= '0;
         miso_q    <= '0;
         done_q    <= 1'b0;
         sck_q     <= 1'b0;
         mosi_q    <= 1'b0;
         csn_q     <= '1;
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         hp_cnt_q  <= hp_cnt_d;
         n_q       <= n_d;
         cpha_q    <= cpha_d;
         lsb_q     <= lsb_d;
         tx_q      <= tx_d;
         rx_q      <= rx_d;
         miso_q    <= miso_d;
         done_q    <= done_d;
         sck_q     <= sck_d;
         mosi_q    <= mosi_d;
         csn_q     <= csn_d;
      end
   end

   assign ready     = (state_q == ST_IDLE);
   assign done      = done_q;
   assign miso_data = miso_q;
   assign spi_sck   = sck_q;
   assign spi_mosi  = mosi_q;
   assign spi_csn   = csn_q;

endmodule
